// File: rtl/config_write_scheduler.sv
// Stages host config writes in a commit-gated FIFO and drains the committed
// batch into config_mem one entry per cycle once frame_sync opens the safe window.
module config_write_scheduler #(
  parameter int DEPTH = 16,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DW-1:0]          host_data,
  input  logic [AW-1:0]          host_addr,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   host_commit,
  input  logic                   frame_sync,
  output logic [DW-1:0]          config_data,
  output logic [AW-1:0]          config_addr,
  output logic                   config_wren,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   busy,
  output logic                   late
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ZERO_P     = {(PW+1){1'b0}};
  localparam logic [PW:0] ONE_P      = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [PW:0] wr_ptr_r, cm_ptr_r, rd_ptr_r;
  logic [PW:0] rem_r, rem_nxt_s;
  logic [PW:0] committed_s;
  logic        push_s, pop_s, late_set_s;

  logic [AW-1:0] addr_mem_r [DEPTH];
  logic [DW-1:0] data_mem_r [DEPTH];

  // Pointer differences carry the wrap bit, so full and empty never alias.
  assign pending     = wr_ptr_r - rd_ptr_r;
  assign committed_s = cm_ptr_r - rd_ptr_r;
  assign host_ready  = (pending < FULL_COUNT);
  assign push_s      = host_valid & host_ready;
  assign busy        = (state_r == ST_DRAIN);

  // Drain sequencing: the first pop happens on the frame_sync edge itself,
  // rem_r counts the pops still owed after that one.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    pop_s       = 1'b0;
    late_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_sync && (committed_s != ZERO_P)) begin
          state_nxt_s = ST_DRAIN;
          rem_nxt_s   = committed_s - ONE_P;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        late_set_s = frame_sync;
        if (rem_r != ZERO_P) begin
          pop_s     = 1'b1;
          rem_nxt_s = rem_r - ONE_P;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        rem_nxt_s   = ZERO_P;
      end
    endcase
  end

  // FIFO pointers, FSM state and sticky late flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= ZERO_P;
      cm_ptr_r <= ZERO_P;
      rd_ptr_r <= ZERO_P;
      rem_r    <= ZERO_P;
      state_r  <= ST_IDLE;
      late     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_P;
      end
      // A same-cycle push joins the commit; with nothing uncommitted this is a no-op.
      if (host_commit) begin
        cm_ptr_r <= wr_ptr_r + (push_s ? ONE_P : ZERO_P);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_P;
      end
      rem_r   <= rem_nxt_s;
      state_r <= state_nxt_s;
      late    <= late | late_set_s;
    end
  end

  // Staging storage; contents are meaningless outside the pointer window.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r[PW-1:0]] <= host_addr;
      data_mem_r[wr_ptr_r[PW-1:0]] <= host_data;
    end
  end

  // Registered config_mem port; address/data hold between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      config_wren <= 1'b0;
      config_addr <= {AW{1'b0}};
      config_data <= {DW{1'b0}};
    end else begin
      config_wren <= pop_s;
      if (pop_s) begin
        config_addr <= addr_mem_r[rd_ptr_r[PW-1:0]];
        config_data <= data_mem_r[rd_ptr_r[PW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_config_write_scheduler.sv
// Directed bench for config_write_scheduler: a queue-based model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_config_write_scheduler;

  localparam int DEPTH = 16;
  localparam int AW    = 8;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] host_data = '0;
  logic [AW-1:0] host_addr = '0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic          host_commit = 1'b0;
  logic          frame_sync = 1'b0;
  logic [DW-1:0] config_data;
  logic [AW-1:0] config_addr;
  logic          config_wren;
  logic [$clog2(DEPTH):0] pending;
  logic          busy;
  logic          late;

  config_write_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_data(host_data), .host_addr(host_addr), .host_valid(host_valid),
    .host_ready(host_ready), .host_commit(host_commit), .frame_sync(frame_sync),
    .config_data(config_data), .config_addr(config_addr), .config_wren(config_wren),
    .pending(pending), .busy(busy), .late(late)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entries in acceptance order; the youngest m_uncomm of them are uncommitted.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t        mq[$];
  int          m_uncomm = 0;
  int          m_left = 0;
  bit          m_busy = 1'b0;
  bit          m_late = 1'b0;
  bit          m_wren = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic m_reset();
    mq.delete();
    m_uncomm = 0; m_left = 0; m_busy = 1'b0; m_late = 1'b0;
    m_wren = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic m_step();
    int   committed;
    bit   acc;
    ent_t e;
    committed = mq.size() - m_uncomm;
    acc = host_valid && (mq.size() < DEPTH);
    if (frame_sync) begin
      if (m_busy) m_late = 1'b1;
      else if (committed > 0) m_left = committed;
    end
    m_wren = 1'b0;
    if (m_left > 0) begin
      e = mq.pop_front();
      m_addr = e.a; m_data = e.d; m_wren = 1'b1;
      m_left--;
    end
    m_busy = m_wren;
    if (acc) begin
      mq.push_back({host_addr, host_data});
      m_uncomm++;
    end
    if (host_commit) m_uncomm = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("wren",    64'(config_wren), 64'(m_wren));
    chk("addr",    64'(config_addr), 64'(m_addr));
    chk("data",    64'(config_data), 64'(m_data));
    chk("pending", 64'(pending),     64'(mq.size()));
    chk("ready",   64'(host_ready),  64'(mq.size() < DEPTH));
    chk("busy",    64'(busy),        64'(m_busy));
    chk("late",    64'(late),        64'(m_late));
  end

  ent_t log_q[$];
  always @(negedge clk) begin
    if (config_wren === 1'b1) log_q.push_back({config_addr, config_data});
  end

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
    host_valid = 1'b1; host_addr = a; host_data = d; host_commit = c;
    @(negedge clk);
    host_valid = 1'b0; host_commit = 1'b0;
  endtask

  task automatic commit();
    host_commit = 1'b1;
    @(negedge clk);
    host_commit = 1'b0;
  endtask

  task automatic fsync();
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(host_ready), 64'd1);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    idle(1);

    // Three committed writes drain in order at t+1..t+3.
    base = log_q.size();
    push(8'h10, 32'hA, 1'b0);
    push(8'h11, 32'hB, 1'b0);
    push(8'h12, 32'hC, 1'b1);
    fsync();
    chk("t1_first_strobe", 64'(config_wren), 64'd1);
    chk("t1_first_addr", 64'(config_addr), 64'h10);
    idle(2);
    chk("t1_last_strobe", 64'(config_wren), 64'd1);
    idle(1);
    chk("t1_after_wren", 64'(config_wren), 64'd0);
    chk("t1_pending", 64'(pending), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_count", 64'(log_q.size() - base), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_log_addr", 64'(log_q[base+i].a), 64'(8'h10 + i));
      chk("t1_log_data", 64'(log_q[base+i].d), 64'(32'hA + i));
    end

    // Uncommitted entries never drain.
    base = log_q.size();
    push(8'h30, 32'h1, 1'b0);
    push(8'h31, 32'h2, 1'b0);
    fsync();
    idle(3);
    chk("t2_count", 64'(log_q.size() - base), 64'd0);
    chk("t2_pending", 64'(pending), 64'd2);
    chk("t2_busy", 64'(busy), 64'd0);
    commit();
    fsync();
    idle(3);
    chk("t2_count_after", 64'(log_q.size() - base), 64'd2);
    chk("t2_log0", 64'(log_q[base]), {24'h0, 8'h30, 32'h1});

    // Fill to DEPTH; the 17th write is held until the first pop frees a slot.
    base = log_q.size();
    host_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      host_addr = 8'h20 + 8'(i); host_data = 32'h100 + 32'(i);
      host_commit = (i == DEPTH - 1);
      @(negedge clk);
    end
    host_commit = 1'b0; host_addr = 8'h7F; host_data = 32'hDEAD;
    chk("t3_full_pending", 64'(pending), 64'd16);
    chk("t3_full_ready", 64'(host_ready), 64'd0);
    idle(2);
    chk("t3_held_pending", 64'(pending), 64'd16);
    fsync();
    chk("t3_ready_after_pop", 64'(host_ready), 64'd1);
    @(negedge clk);
    host_valid = 1'b0;
    chk("t3_pending_accept", 64'(pending), 64'd15);
    idle(20);
    chk("t3_count", 64'(log_q.size() - base), 64'd16);
    for (int i = 0; i < DEPTH; i++)
      chk("t3_log", 64'(log_q[base+i]), {24'h0, 8'(8'h20 + i), 32'(32'h100 + i)});
    chk("t3_left", 64'(pending), 64'd1);
    commit();
    fsync();
    idle(3);
    chk("t3_17th", 64'(log_q[base+16]), {24'h0, 8'h7F, 32'hDEAD});

    // A second frame_sync inside the window is flagged late and ignored.
    base = log_q.size();
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 32'h400 + 32'(i), i == 3);
    chk("t4_late_before", 64'(late), 64'd0);
    fsync();
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    chk("t4_late", 64'(late), 64'd1);
    @(negedge clk);
    chk("t4_busy_t4", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t4_busy_t5", 64'(busy), 64'd0);
    idle(3);
    chk("t4_count", 64'(log_q.size() - base), 64'd4);

    // A commit during the window waits for the next frame_sync.
    base = log_q.size();
    push(8'h50, 32'h500, 1'b0);
    push(8'h51, 32'h501, 1'b1);
    fsync();
    push(8'h52, 32'h502, 1'b1);
    idle(4);
    chk("t5_count", 64'(log_q.size() - base), 64'd2);
    chk("t5_pending", 64'(pending), 64'd1);
    fsync();
    idle(2);
    chk("t5_count_next", 64'(log_q.size() - base), 64'd3);
    chk("t5_third", 64'(log_q[base+2]), {24'h0, 8'h52, 32'h502});

    // Reset after the second of five strobes aborts the drain.
    base = log_q.size();
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 32'h600 + 32'(i), i == 4);
    fsync();
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_wren_rst", 64'(config_wren), 64'd0);
    chk("t6_pending_rst", 64'(pending), 64'd0);
    chk("t6_late_rst", 64'(late), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    fsync();
    idle(3);
    chk("t6_count", 64'(log_q.size() - base), 64'd2);
    chk("t6_pending", 64'(pending), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_write_scheduler.md
CONFIG_WRITE_SCHEDULER -- requirements
Module: config_write_scheduler

Interface
REQ-001 Parameter DEPTH, default 16: staging FIFO entries; power of two, 4..64.
REQ-002 Parameter AW, default 8: config address width.
REQ-003 Parameter DW, default 32: config data width.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous assert, active-low reset.
REQ-006 host_data  in  DW  config word from host.
REQ-007 host_addr  in  AW  target config_mem address.
REQ-008 host_valid  in  1  host offers a write.
REQ-009 host_ready  out  1  FIFO can accept; transfer occurs when host_valid and host_ready are both high.
REQ-010 host_commit  in  1  one-cycle pulse; all accepted writes become eligible to drain.
REQ-011 frame_sync  in  1  one-cycle pulse from CPU side; safe window for config_mem updates opens.
REQ-012 config_data  out  DW  write data to config_mem.
REQ-013 config_addr  out  AW  write address to config_mem.
REQ-014 config_wren  out  1  write strobe to config_mem.
REQ-015 pending  out  $clog2(DEPTH)+1  entries held (committed plus uncommitted).
REQ-016 busy  out  1  high while in DRAIN.
REQ-017 late  out  1  sticky; frame_sync arrived while in DRAIN.

Function
REQ-018 Staging is a DEPTH-entry FIFO with separate pointers: write pointer, commit pointer, read pointer.
REQ-019 host_ready = (pending < DEPTH); a full FIFO never drops or overwrites.
REQ-020 A push on the same cycle as host_commit is included in that commit.
REQ-021 host_commit with no uncommitted entries is a no-op.
REQ-022 Uncommitted entries never drain.
REQ-023 FSM states: IDLE and DRAIN.
REQ-024 IDLE -> DRAIN: on frame_sync when the committed count (pre-commit value that cycle) is nonzero; this count is snapshotted as the drain length N.
REQ-025 IDLE, frame_sync with zero committed entries: stay IDLE; no writes.
REQ-026 DRAIN: pop one entry per cycle. Registered config_wren=1 with that entry's addr/data. Exactly N consecutive strobes.
REQ-027 Latency: frame_sync at cycle t gives first config_wren at t+1 and last at t+N. The FSM returns to IDLE so busy=0 at t+N+1.
REQ-028 Commits during DRAIN do not extend N; those entries wait for the next frame_sync.
REQ-029 frame_sync during DRAIN is ignored for scheduling and sets late=1. late clears only on reset.
REQ-030 Pushes during DRAIN are permitted. A simultaneous push and pop leaves pending unchanged.
REQ-031 When config_wren=0, config_addr and config_data hold their last value.
REQ-032 Pointers wrap modulo DEPTH; full/empty are distinguished by the extra pointer bit.
REQ-033 Writes are applied in acceptance order; duplicate addresses are not merged.

Reset
REQ-034 reset_n low asynchronously clears all pointers and the FSM (to IDLE). It also clears late and zeros config_wren, config_addr and config_data.
REQ-035 Reset mid-DRAIN aborts immediately. All staged entries are discarded, and no further config_wren occurs until a new commit and frame_sync.
REQ-036 After reset: host_ready=1, pending=0, busy=0.

Verification
REQ-037 Push 3 writes (addr 0x10/0x11/0x12, data 0xA/0xB/0xC), commit, frame_sync at t -> config_wren at t+1..t+3 with those pairs in order; pending=0 at t+4.
REQ-038 Push 2 with no commit, then frame_sync -> no config_wren; pending=2; busy=0.
REQ-039 Push DEPTH writes with host_valid held high -> host_ready=0 at pending=DEPTH; a 17th write is held, not lost; it is accepted in the cycle after the first pop.
REQ-040 Commit 4, frame_sync, second frame_sync 2 cycles later -> exactly 4 strobes; late=1; busy drops at t+5.
REQ-041 Commit 2, push 1 more and commit during DRAIN -> 2 strobes this window; the third entry is drained on the next frame_sync.
REQ-042 Assert reset_n=0 after the 2nd of 5 strobes -> config_wren=0 immediately; pending=0; a later frame_sync produces no write.
